// File: rtl/fp_pkg.sv
// Shared types and helpers for the pipelined floating-point multiplier.
package fp_pkg;

  typedef enum logic [1:0] {
    FP_ZERO = 2'd0,
    FP_NORM = 2'd1,
    FP_INF  = 2'd2,
    FP_NAN  = 2'd3
  } fp_class_e;

  localparam int FLG_INV = 3;
  localparam int FLG_OVF = 2;
  localparam int FLG_UNF = 1;
  localparam int FLG_INX = 0;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Canonical quiet NaN {0, all-ones, 1, 0..0}, right-aligned in a wide vector.
  function automatic logic [127:0] fp_qnan(input int exp_w, input int man_w);
    logic [127:0] q;
    q = ((128'd1 << exp_w) - 128'd1) << man_w;
    q = q | (128'd1 << (man_w - 1));
    return q;
  endfunction

endpackage

// File: rtl/fp_unpack.sv
// Splits one operand into sign/exponent/significand and classifies it.
module fp_unpack
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W+MAN_W:0] x,
  output logic                 sign,
  output logic [EXP_W-1:0]     expo,
  output logic [MAN_W:0]       sig,
  output logic [1:0]           cls
);

  logic [MAN_W-1:0] frac;

  assign sign = x[EXP_W+MAN_W];
  assign expo = x[EXP_W+MAN_W-1:MAN_W];
  assign frac = x[MAN_W-1:0];
  assign sig  = {1'b1, frac};

  // Subnormals are flushed: a zero exponent is ZERO regardless of fraction.
  always_comb begin
    cls = FP_NORM;
    if (expo == '0)
      cls = FP_ZERO;
    else if (&expo)
      cls = (frac != '0) ? FP_NAN : FP_INF;
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// 3-stage pipelined FP multiplier with valid/ready handshake and RNE rounding.
// Define FP_MUL_FLAGS_EN to compute and register the exception flags.
module fp_mul_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] result,
  output logic [TAG_W-1:0]     out_tag,
  output logic [3:0]           flags
);

  localparam int XLEN = 1 + EXP_W + MAN_W;
  localparam int ES_W = EXP_W + 2;
  localparam int PW   = 2 * MAN_W + 2;
  localparam logic signed [ES_W-1:0] BIAS_S   = ES_W'(fp_bias(EXP_W));
  localparam logic signed [ES_W-1:0] EXP_ALL1 = ES_W'((1 << EXP_W) - 1);
  localparam logic [127:0]           QNAN_W   = fp_qnan(EXP_W, MAN_W);
  localparam logic [XLEN-1:0]        QNAN     = QNAN_W[XLEN-1:0];

  // Returns {carry_out, rounded_fraction}; carry means the significand wrapped to 2.0.
  function automatic logic [MAN_W:0] round_rne(input logic [MAN_W-1:0] frac,
                                               input logic guard, input logic sticky);
    logic up;
    up = guard & (sticky | frac[0]);
    return {1'b0, frac} + {{MAN_W{1'b0}}, up};
  endfunction

  logic advance;
  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  logic             ua_sign, ub_sign;
  logic [EXP_W-1:0] ua_exp, ub_exp;
  logic [MAN_W:0]   ua_sig, ub_sig;
  logic [1:0]       ua_cls, ub_cls;

  fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_a (
    .x(a), .sign(ua_sign), .expo(ua_exp), .sig(ua_sig), .cls(ua_cls)
  );
  fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_b (
    .x(b), .sign(ub_sign), .expo(ub_exp), .sig(ub_sig), .cls(ub_cls)
  );

  logic signed [ES_W-1:0] exp_sum_s1;
  assign exp_sum_s1 = $signed({2'b00, ua_exp}) + $signed({2'b00, ub_exp}) - BIAS_S;

  // ---- S1: unpack / classify / exponent sum
  logic                   vld_p1, sign_p1;
  fp_class_e              cls_a_p1, cls_b_p1;
  logic signed [ES_W-1:0] exp_p1;
  logic [MAN_W:0]         sig_a_p1, sig_b_p1;
  logic [TAG_W-1:0]       tag_p1;

  always_ff @(posedge clk) begin
    if (rst)
      vld_p1 <= 1'b0;
    else if (advance)
      vld_p1 <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      sign_p1  <= ua_sign ^ ub_sign;
      cls_a_p1 <= fp_class_e'(ua_cls);
      cls_b_p1 <= fp_class_e'(ub_cls);
      exp_p1   <= exp_sum_s1;
      sig_a_p1 <= ua_sig;
      sig_b_p1 <= ub_sig;
      tag_p1   <= in_tag;
    end
  end

  // ---- S2: significand multiply
  logic                   vld_p2, sign_p2;
  fp_class_e              cls_a_p2, cls_b_p2;
  logic signed [ES_W-1:0] exp_p2;
  logic [PW-1:0]          prod_p2;
  logic [TAG_W-1:0]       tag_p2;

  always_ff @(posedge clk) begin
    if (rst)
      vld_p2 <= 1'b0;
    else if (advance)
      vld_p2 <= vld_p1;
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      sign_p2  <= sign_p1;
      cls_a_p2 <= cls_a_p1;
      cls_b_p2 <= cls_b_p1;
      exp_p2   <= exp_p1;
      prod_p2  <= PW'(sig_a_p1) * PW'(sig_b_p1);
      tag_p2   <= tag_p1;
    end
  end

  // ---- S3: normalise / round / pack
  logic                   hi_s3, guard_s3, sticky_s3;
  logic [PW-2:0]          norm_s3;
  logic [MAN_W:0]         rnd_s3;
  logic signed [ES_W-1:0] exp_fin_s3;
  logic                   is_inv_s3, is_inf_s3, is_zero_s3, is_ovf_s3, is_unf_s3;
  logic [XLEN-1:0]        res_s3;

  // norm_s3 holds the bits below the leading one after the optional 1-bit right shift.
  assign hi_s3      = prod_p2[PW-1];
  assign norm_s3    = hi_s3 ? prod_p2[PW-2:0] : {prod_p2[PW-3:0], 1'b0};
  assign guard_s3   = norm_s3[MAN_W];
  assign sticky_s3  = |norm_s3[MAN_W-1:0];
  assign rnd_s3     = round_rne(norm_s3[PW-2:MAN_W+1], guard_s3, sticky_s3);
  assign exp_fin_s3 = exp_p2 + $signed({{(ES_W-1){1'b0}}, hi_s3})
                             + $signed({{(ES_W-1){1'b0}}, rnd_s3[MAN_W]});

  assign is_inv_s3  = (cls_a_p2 == FP_NAN) || (cls_b_p2 == FP_NAN) ||
                      (cls_a_p2 == FP_INF && cls_b_p2 == FP_ZERO) ||
                      (cls_a_p2 == FP_ZERO && cls_b_p2 == FP_INF);
  assign is_inf_s3  = (cls_a_p2 == FP_INF) || (cls_b_p2 == FP_INF);
  assign is_zero_s3 = (cls_a_p2 == FP_ZERO) || (cls_b_p2 == FP_ZERO);
  assign is_ovf_s3  = exp_fin_s3 >= EXP_ALL1;
  assign is_unf_s3  = exp_fin_s3[ES_W-1] || (exp_fin_s3 == '0);

  always_comb begin
    res_s3 = {sign_p2, exp_fin_s3[EXP_W-1:0], rnd_s3[MAN_W-1:0]};
    if (is_inv_s3)
      res_s3 = QNAN;
    else if (is_inf_s3 || is_ovf_s3)
      res_s3 = {sign_p2, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (is_zero_s3 || is_unf_s3)
      res_s3 = {sign_p2, {(XLEN-1){1'b0}}};
  end

  logic                 vld_p3;
  logic [XLEN-1:0]      res_p3;
  logic [TAG_W-1:0]     tag_p3;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p3 <= 1'b0;
      res_p3 <= '0;
      tag_p3 <= '0;
    end else if (advance) begin
      vld_p3 <= vld_p2;
      res_p3 <= res_s3;
      tag_p3 <= tag_p2;
    end
  end

  assign out_valid = vld_p3;
  assign result    = res_p3;
  assign out_tag   = tag_p3;

`ifdef FP_MUL_FLAGS_EN
  logic [3:0] flg_s3, flg_p3;

  always_comb begin
    flg_s3 = '0;
    if (is_inv_s3)
      flg_s3[FLG_INV] = 1'b1;
    else if (!is_inf_s3 && !is_zero_s3) begin
      if (is_ovf_s3) begin
        flg_s3[FLG_OVF] = 1'b1;
        flg_s3[FLG_INX] = 1'b1;
      end else if (is_unf_s3) begin
        flg_s3[FLG_UNF] = 1'b1;
        flg_s3[FLG_INX] = 1'b1;
      end else
        flg_s3[FLG_INX] = guard_s3 | sticky_s3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      flg_p3 <= '0;
    else if (advance)
      flg_p3 <= flg_s3;
  end

  assign flags = flg_p3;
`else
  assign flags = '0;
`endif

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Self-checking bench for fp_mul_pipe (EXP_W=8, MAN_W=23) with a real-number-style reference model.
module tb_fp_mul_pipe;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, result;
  logic [3:0]  in_tag, out_tag, flags;

  int checks = 0;
  int errors = 0;
  logic [39:0] exp_q[$];

  always #5 clk = ~clk;

  fp_mul_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .out_tag(out_tag), .flags(flags)
  );

  function automatic logic [3:0] fmask(input logic [3:0] f);
`ifdef FP_MUL_FLAGS_EN
    return f;
`else
    return 4'b0000 & f;
`endif
  endfunction

  // Reference: exact integer product of the significands, rounded by remainder comparison.
  function automatic logic [35:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    logic s, nx, ny, ix, iy, zx, zy;
    int ex, ey, e, k;
    longint fx, fy, p, q, r, half;
    logic [31:0] res;
    logic [3:0]  fl;
    s  = x[31] ^ y[31];
    ex = int'(x[30:23]);  ey = int'(y[30:23]);
    fx = longint'(x[22:0]); fy = longint'(y[22:0]);
    zx = (ex == 0);  zy = (ey == 0);
    nx = (ex == 255) && (fx != 0);  ny = (ey == 255) && (fy != 0);
    ix = (ex == 255) && (fx == 0);  iy = (ey == 255) && (fy == 0);
    fl = 4'b0000;
    if (nx || ny || (ix && zy) || (zx && iy)) begin
      res = 32'h7FC00000; fl = 4'b1000;
    end else if (ix || iy) begin
      res = {s, 8'hFF, 23'h0};
    end else if (zx || zy) begin
      res = {s, 31'h0};
    end else begin
      p = ((longint'(1) << 23) | fx) * ((longint'(1) << 23) | fy);
      e = ex + ey - 127;
      if (p >= (longint'(1) << 47)) begin k = 24; e = e + 1; end
      else k = 23;
      q    = p >> k;
      r    = p - (q << k);
      half = longint'(1) << (k - 1);
      if (r > half || (r == half && (q % 2) == 1)) q = q + 1;
      if (q == (longint'(1) << 24)) begin q = q >> 1; e = e + 1; end
      if (e >= 255) begin
        res = {s, 8'hFF, 23'h0}; fl = 4'b0101;
      end else if (e <= 0) begin
        res = {s, 31'h0}; fl = 4'b0011;
      end else begin
        res = {s, 8'(e), 23'(q)}; fl = {3'b000, r != 0};
      end
    end
    return {fmask(fl), res};
  endfunction

  function automatic logic [31:0] gen_op();
    logic [31:0] v;
    int m;
    m = $urandom_range(0, 9);
    v = $urandom;
    if (m == 0) begin
      case ($urandom_range(0, 6))
        0: v = 32'h00000000;
        1: v = 32'h80000000;
        2: v = 32'h7F800000;
        3: v = 32'hFF800000;
        4: v = 32'h7FC00001;
        5: v = 32'h00012345;
        default: v = 32'hFFFFFFFF;
      endcase
    end else begin
      v[30:23] = (m < 6) ? 8'($urandom_range(100, 154)) : 8'($urandom_range(1, 254));
      if (m == 1) v[22:0] = 23'h7FFFFF;
    end
    return v;
  endfunction

  task automatic run_one(input logic [31:0] xa, input logic [31:0] xb, input logic [3:0] t,
                         output logic [31:0] r, output logic [3:0] ot, output logic [3:0] fl,
                         output int lat);
    @(negedge clk);
    a = xa; b = xb; in_tag = t; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    r = result; ot = out_tag; fl = flags;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; in_tag = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected 0", result); end
    checks++; if (out_tag !== 4'h0) begin errors++; $display("FAIL reset_tag: got %h expected 0", out_tag); end
    checks++; if (flags !== 4'h0) begin errors++; $display("FAIL reset_flags: got %h expected 0", flags); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [31:0] va[7] = '{32'h40000000, 32'h3F800001, 32'h3FC00000, 32'h7F000000,
                           32'h00800000, 32'h7F800000, 32'hFF800000};
    logic [31:0] vb[7] = '{32'h40400000, 32'h3F800001, 32'h3FC00000, 32'h7F000000,
                           32'h3E800000, 32'h80000000, 32'h40000000};
    logic [31:0] vr[7] = '{32'h40C00000, 32'h3F800002, 32'h40100000, 32'h7F800000,
                           32'h00000000, 32'h7FC00000, 32'hFF800000};
    logic [3:0]  vf[7] = '{4'h0, 4'h1, 4'h0, 4'h5, 4'h3, 4'h8, 4'h0};
    logic [31:0] r;
    logic [3:0]  ot, fl, t;
    int lat;
    for (int i = 0; i < 7; i++) begin
      t = 4'(i + 5);
      run_one(va[i], vb[i], t, r, ot, fl, lat);
      checks++; if (lat !== 3) begin errors++; $display("FAIL dir%0d_latency: got %0d expected 3", i, lat); end
      checks++; if (r !== vr[i]) begin errors++; $display("FAIL dir%0d_result: got %h expected %h", i, r, vr[i]); end
      checks++; if (ot !== t) begin errors++; $display("FAIL dir%0d_tag: got %h expected %h", i, ot, t); end
      checks++; if (fl !== fmask(vf[i])) begin errors++; $display("FAIL dir%0d_flags: got %h expected %h", i, fl, fmask(vf[i])); end
    end
  endtask

  task automatic test_back_to_back();
    int sent = 0, got = 0;
    logic have_held = 1'b0, saw_stall = 1'b0;
    logic [31:0] held_r;
    logic [3:0]  held_t;
    logic [39:0] e;
    exp_q.delete();
    for (int cyc = 0; cyc < 40 && (sent < 4 || exp_q.size() > 0); cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 8);
      in_valid  = (sent < 4);
      a = gen_op(); b = gen_op(); in_tag = 4'(sent + 8);
      #1;
      if (out_valid && !out_ready) begin
        if (have_held) begin
          checks++;
          if (result !== held_r || out_tag !== held_t) begin
            errors++; $display("FAIL b2b_hold: got %h/%h expected %h/%h", result, out_tag, held_r, held_t);
          end
        end
        held_r = result; held_t = out_tag; have_held = 1'b1;
      end
      if (in_valid && !in_ready) saw_stall = 1'b1;
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_extra: got tag %h expected no output", out_tag);
        end else begin
          e = exp_q.pop_front();
          if ({out_tag, flags, result} !== e) begin
            errors++; $display("FAIL b2b_out: got %h expected %h", {out_tag, flags, result}, e);
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin exp_q.push_back({in_tag, ref_mul(a, b)}); sent++; end
    end
    @(negedge clk) in_valid = 1'b0;
    checks++; if (saw_stall !== 1'b1) begin errors++; $display("FAIL b2b_in_ready: got no stall expected in_ready low"); end
    checks++; if (got != 4 || exp_q.size() != 0) begin errors++; $display("FAIL b2b_count: got %0d expected 4", got); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_dup: got out_valid %b expected 0", out_valid); end
    end
  endtask

  task automatic test_random(input int n);
    int sent = 0, cyc = 0;
    logic [39:0] e;
    exp_q.delete();
    while ((sent < n || exp_q.size() > 0) && cyc < n * 20) begin
      @(negedge clk);
      cyc++;
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = (sent < n) && ($urandom_range(0, 4) != 0);
      a = gen_op(); b = gen_op(); in_tag = 4'($urandom);
      #1;
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rand_extra: got %h expected no output", result);
        end else begin
          e = exp_q.pop_front();
          if ({out_tag, flags, result} !== e) begin
            errors++; $display("FAIL rand_out: got %h expected %h", {out_tag, flags, result}, e);
          end
        end
      end
      if (in_valid && in_ready) begin exp_q.push_back({in_tag, ref_mul(a, b)}); sent++; end
    end
    @(negedge clk) in_valid = 1'b0;
    checks++; if (sent != n || exp_q.size() != 0) begin errors++; $display("FAIL rand_timeout: got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    logic [3:0]  ot, fl;
    int lat, stale = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1; a = gen_op(); b = gen_op(); in_tag = 4'(i + 1);
    end
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0", out_valid); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL rstmid_result: got %h expected 0", result); end
    rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stale++;
    end
    checks++; if (stale != 0) begin errors++; $display("FAIL rstmid_stale: got %0d outputs expected 0", stale); end
    run_one(32'h40000000, 32'h40400000, 4'h9, r, ot, fl, lat);
    checks++; if (r !== 32'h40C00000 || ot !== 4'h9) begin
      errors++; $display("FAIL rstmid_after: got %h/%h expected 40c00000/9", r, ot);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; in_tag = '0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_random(300);
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
